reg_file_sb: RTL and testbench

Parametrised register file with two combinational read ports, one synchronous write port, and a per-register busy scoreboard. It is the next-generation register file for the datapath: width and depth are configurable, an optional hardwired-zero register is supported, and an issue stage can claim registers while writeback releases them. Operand-hazard stall decisions are made in the issue stage from the busy flags and busy count.

---
 rtl/reg_file_sb.sv | 95 +++++++++
 tb/tb_reg_file_sb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one write port and a busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data and release to the read ports.
module reg_file_sb #(
  parameter int DSIZE    = 16,
  parameter int RSIZE    = 4,
  parameter int ZERO_REG = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Wen,
  input  logic [RSIZE-1:0] WAddr,
  input  logic [DSIZE-1:0] WData,
  input  logic [RSIZE-1:0] RAddr1,
  input  logic [RSIZE-1:0] RAddr2,
  output logic [DSIZE-1:0] RData1,
  output logic [DSIZE-1:0] RData2,
  input  logic             Claim,
  input  logic [RSIZE-1:0] CAddr,
  output logic             Busy1,
  output logic             Busy2,
  output logic [RSIZE:0]   BusyCount
);

  localparam int   DEPTH = 1 << RSIZE;
  localparam int   CW    = RSIZE + 1;
  localparam logic ZR    = (ZERO_REG != 0);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [CW-1:0]    count;
  logic             wr_ok;
  logic             cl_ok;
  logic             inc;
  logic             dec;

  // A release cancelled by a same-cycle claim of the same register
  // leaves that register busy, so it must not decrement the count.
  always_comb begin
    wr_ok = Wen && !(ZR && WAddr == '0);
    cl_ok = Claim && !(ZR && CAddr == '0);
    inc   = cl_ok && !busy[CAddr];
    dec   = wr_ok && busy[WAddr]
            && !(cl_ok && CAddr == WAddr);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        mem[WAddr]  <= WData;
        busy[WAddr] <= 1'b0;
      end
      if (cl_ok) begin
        busy[CAddr] <= 1'b1;
      end
      count <= count + CW'(inc) - CW'(dec);
    end
  end

  function automatic logic [DSIZE-1:0] rdata(
    input logic [RSIZE-1:0] a
  );
    logic [DSIZE-1:0] d;
    d = mem[a];
`ifdef RF_BYPASS_EN
    if (wr_ok && WAddr == a) d = WData;
`endif
    if (ZR && a == '0) d = '0;
    return d;
  endfunction

  function automatic logic rbusy(
    input logic [RSIZE-1:0] a
  );
    logic b;
    b = busy[a];
`ifdef RF_BYPASS_EN
    if (wr_ok && WAddr == a) b = cl_ok && CAddr == WAddr;
`endif
    if (ZR && a == '0) b = 1'b0;
    return b;
  endfunction

  assign RData1    = rdata(RAddr1);
  assign RData2    = rdata(RAddr2);
  assign Busy1     = rbusy(RAddr1);
  assign Busy2     = rbusy(RAddr2);
  assign BusyCount = count;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed plan plus random traffic on two
// instances (ZERO_REG=0 and ZERO_REG=1) against an array-based model.
module tb_reg_file_sb;

  logic        Clock;
  logic        Reset;
  logic        Wen;
  logic        Claim;
  logic [3:0]  WAddr;
  logic [3:0]  RAddr1;
  logic [3:0]  RAddr2;
  logic [3:0]  CAddr;
  logic [15:0] WData;

  logic [15:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        b1_0, b2_0, b1_1, b2_1;
  logic [4:0]  bc_0, bc_1;

  int total = 0;
  int bad   = 0;

  logic [15:0] mm [2][16];
  bit          bm [2][16];

  reg_file_sb #(.DSIZE(16), .RSIZE(4), .ZERO_REG(0)) u0 (
    .Clock(Clock), .Reset(Reset), .Wen(Wen), .WAddr(WAddr),
    .WData(WData), .RAddr1(RAddr1), .RAddr2(RAddr2),
    .RData1(rd1_0), .RData2(rd2_0), .Claim(Claim),
    .CAddr(CAddr), .Busy1(b1_0), .Busy2(b2_0),
    .BusyCount(bc_0)
  );

  reg_file_sb #(.DSIZE(16), .RSIZE(4), .ZERO_REG(1)) u1 (
    .Clock(Clock), .Reset(Reset), .Wen(Wen), .WAddr(WAddr),
    .WData(WData), .RAddr1(RAddr1), .RAddr2(RAddr2),
    .RData1(rd1_1), .RData2(rd2_1), .Claim(Claim),
    .CAddr(CAddr), .Busy1(b1_1), .Busy2(b2_1),
    .BusyCount(bc_1)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(int d, int a);
    logic [15:0] v;
    v = mm[d][a];
`ifdef RF_BYPASS_EN
    if (Wen && int'(WAddr) == a && !(d == 1 && a == 0))
      v = WData;
`endif
    if (d == 1 && a == 0) v = '0;
    return v;
  endfunction

  function automatic logic exp_busy(int d, int a);
    logic v;
    v = bm[d][a];
`ifdef RF_BYPASS_EN
    if (Wen && int'(WAddr) == a && !(d == 1 && a == 0))
      v = Claim && CAddr == WAddr;
`endif
    if (d == 1 && a == 0) v = 1'b0;
    return v;
  endfunction

  function automatic logic [4:0] exp_cnt(int d);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(bm[d][i]);
    return 5'(n);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!Reset) begin
        for (int i = 0; i < 16; i++) begin
          mm[d][i] = '0;
          bm[d][i] = 1'b0;
        end
      end else begin
        if (Wen && !(d == 1 && WAddr == 0)) begin
          mm[d][WAddr] = WData;
          bm[d][WAddr] = 1'b0;
        end
        if (Claim && !(d == 1 && CAddr == 0))
          bm[d][CAddr] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, "_rd1_z0"}, rd1_0, exp_rd(0, RAddr1));
    chk({tag, "_rd2_z0"}, rd2_0, exp_rd(0, RAddr2));
    chk({tag, "_b1_z0"}, b1_0, exp_busy(0, RAddr1));
    chk({tag, "_b2_z0"}, b2_0, exp_busy(0, RAddr2));
    chk({tag, "_cnt_z0"}, bc_0, exp_cnt(0));
    chk({tag, "_rd1_z1"}, rd1_1, exp_rd(1, RAddr1));
    chk({tag, "_rd2_z1"}, rd2_1, exp_rd(1, RAddr2));
    chk({tag, "_b1_z1"}, b1_1, exp_busy(1, RAddr1));
    chk({tag, "_b2_z1"}, b2_1, exp_busy(1, RAddr2));
    chk({tag, "_cnt_z1"}, bc_1, exp_cnt(1));
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
  endtask

  task automatic idle();
    Wen   = 1'b0;
    Claim = 1'b0;
  endtask

  logic [4:0] cnt_before;

  initial begin
    Reset = 1'b0; Wen = 1'b0; Claim = 1'b0;
    WAddr = '0; WData = '0; CAddr = '0;
    RAddr1 = '0; RAddr2 = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        mm[d][i] = 'x;
        bm[d][i] = 1'b0;
      end
    step();
    Reset = 1'b1;
    check_all("reset");
    chk("reset_rd1", rd1_0, 16'h0000);
    chk("reset_cnt", bc_0, 5'd0);

    for (int i = 0; i < 16; i++) begin
      Wen = 1'b1; WAddr = 4'(i); WData = 16'(i + 16);
      check_all("fill_w");
      step();
    end
    idle();
    for (int i = 0; i < 15; i++) begin
      RAddr1 = 4'(i); RAddr2 = 4'(i + 1);
      check_all("fill_r");
      chk("fill_rd1", rd1_0, 16'(i + 16));
      chk("fill_rd2", rd2_0, 16'(i + 17));
    end
    RAddr1 = 4'd0;
    #1 chk("zero_fill_rd1", rd1_1, 16'h0000);

    RAddr1 = 4'd3;
    Claim = 1'b1; CAddr = 4'd3; step();
    chk("sb_cnt_a", bc_0, 5'd1);
    chk("sb_busy_a", b1_0, 1'b1);
    CAddr = 4'd5; step();
    chk("sb_cnt_b", bc_0, 5'd2);
    step();
    chk("sb_cnt_c", bc_0, 5'd2);
    Claim = 1'b0; Wen = 1'b1; WAddr = 4'd3; WData = 16'h00AA;
    check_all("sb_rel");
    step();
    idle();
    check_all("sb_post");
    chk("sb_cnt_d", bc_0, 5'd1);
    chk("sb_busy_d", b1_0, 1'b0);
    chk("sb_rd", rd1_0, 16'h00AA);

    Claim = 1'b1; CAddr = 4'd7;
    Wen = 1'b1; WAddr = 4'd7; WData = 16'h1234;
    RAddr1 = 4'd7;
    check_all("sim");
    step();
    idle();
    check_all("sim_post");
    chk("sim_rd", rd1_0, 16'h1234);
    chk("sim_busy", b1_0, 1'b1);
    chk("sim_cnt", bc_0, 5'd2);

    Wen = 1'b1; WAddr = 4'd4; WData = 16'h0011; step();
    RAddr1 = 4'd4; WData = 16'hBEEF;
    check_all("byp");
`ifdef RF_BYPASS_EN
    chk("byp_same", rd1_0, 16'hBEEF);
`else
    chk("byp_same", rd1_0, 16'h0011);
`endif
    step();
    idle();
    chk("byp_after", rd1_0, 16'hBEEF);

    Claim = 1'b1;
    for (int i = 0; i < 16; i++) begin
      CAddr = 4'(i);
      check_all("sat");
      step();
    end
    idle();
    check_all("sat_full");
    chk("sat_cnt_z0", bc_0, 5'h10);
    chk("sat_cnt_z1", bc_1, 5'h0F);
    Reset = 1'b0; Wen = 1'b1; WAddr = 4'd2; WData = 16'h5555;
    step();
    Reset = 1'b1; idle();
    chk("mid_cnt", bc_0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      RAddr1 = 4'(i); RAddr2 = 4'(15 - i);
      check_all("mid");
      chk("mid_busy", b1_0, 1'b0);
    end
    RAddr1 = 4'd2;
    #1 chk("mid_rd", rd1_0, 16'h0000);

    Claim = 1'b1; CAddr = 4'd9; step();
    cnt_before = bc_1;
    Wen = 1'b1; WAddr = 4'd0; WData = 16'hFFFF;
    Claim = 1'b1; CAddr = 4'd0; RAddr1 = 4'd0;
    check_all("zr");
    step();
    idle();
    check_all("zr_post");
    chk("zr_rd", rd1_1, 16'h0000);
    chk("zr_busy", b1_1, 1'b0);
    chk("zr_cnt", bc_1, cnt_before);
    chk("zr_cnt_val", bc_1, 5'd1);

    for (int n = 0; n < 400; n++) begin
      Reset  = ($urandom_range(0, 49) != 0);
      Wen    = $urandom_range(0, 1) == 1;
      Claim  = $urandom_range(0, 2) != 0;
      WAddr  = 4'($urandom_range(0, 15));
      CAddr  = ($urandom_range(0, 3) == 0) ? WAddr
                                           : 4'($urandom_range(0, 15));
      WData  = 16'($urandom);
      RAddr1 = ($urandom_range(0, 3) == 0) ? WAddr
                                           : 4'($urandom_range(0, 15));
      RAddr2 = ($urandom_range(0, 3) == 0) ? RAddr1
                                           : 4'($urandom_range(0, 15));
      check_all("rnd");
      step();
    end
    Reset = 1'b1; idle();
    check_all("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
